spi_flash_responder: RTL and testbench

SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

---
 rtl/spi_flash_pkg.sv | 14 +
 rtl/spi_edge_sync.sv | 36 +++
 rtl/spi_flash_responder.sv | 153 +++++++++++++++
 tb/tb_spi_flash_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: state encoding, opcodes and data-source selectors for the SPI flash responder.
package spi_flash_pkg;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_IGNORE = 3'd4;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_RDID  = 8'h9F;
    localparam logic [7:0] CMD_RDSR  = 8'h05;
    localparam logic [1:0] SRC_MEM   = 2'd0;
    localparam logic [1:0] SRC_ID    = 2'd1;
    localparam logic [1:0] SRC_SR    = 2'd2;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: 2-flop synchronizers for CS/SCLK/MOSI; a third stage on CS and SCLK
// yields single-cycle rise/fall strobes.
module spi_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic cs_i,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic cs_o,
    output logic mosi_o,
    output logic cs_rise_o,
    output logic cs_fall_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o
);
    logic [2:0] cs_q;
    logic [2:0] sclk_q;
    logic [1:0] mosi_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_q   <= '1;
            sclk_q <= '0;
            mosi_q <= '0;
        end else begin
            cs_q   <= {cs_q[1:0], cs_i};
            sclk_q <= {sclk_q[1:0], sclk_i};
            mosi_q <= {mosi_q[0], mosi_i};
        end
    end
    assign cs_o        = cs_q[2];
    assign mosi_o      = mosi_q[1];
    assign cs_rise_o   = cs_q[1] & ~cs_q[2];
    assign cs_fall_o   = ~cs_q[1] & cs_q[2];
    assign sclk_rise_o = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall_o = ~sclk_q[1] & sclk_q[2];
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 flash slave answering READ (0x03), RDID (0x9F) and RDSR (0x05)
// from a byte memory with a one-byte prefetch, all logic in the CLK domain.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          MEM_AW   = 16,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SPI_CS,
    input  logic              SPI_SCLK,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic              MISO_OE,
    output logic [MEM_AW-1:0] MEM_ADDR,
    output logic              MEM_RD,
    input  logic [7:0]        MEM_RDATA
);
    logic              cs_s, mosi, cs_rise, cs_fall, sclk_rise, sclk_fall;
    logic [2:0]        state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [MEM_AW-2:0] sh_q, sh_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [7:0]        tx_q, tx_d, pf_q, pf_d, byte_v, id_byte, cmd;
    logic [1:0]        src_q, src_d, idx_q, idx_d, warm_q, warm_d;
    logic              miso_q, miso_d, oe_q, oe_d, rd_q, rd_d, req_q, req_d, cap_q, cap_d;
    logic              load_q, load_d, armed_q, armed_d;

    spi_edge_sync u_sync (
        .clk(CLK), .rst(RST), .cs_i(SPI_CS), .sclk_i(SPI_SCLK), .mosi_i(SPI_MOSI),
        .cs_o(cs_s), .mosi_o(mosi), .cs_rise_o(cs_rise), .cs_fall_o(cs_fall),
        .sclk_rise_o(sclk_rise), .sclk_fall_o(sclk_fall)
    );

    assign cmd     = {sh_q[6:0], mosi};
    assign id_byte = (idx_q == 2'd0) ? JEDEC_ID[23:16] : (idx_q == 2'd1) ? JEDEC_ID[15:8] : JEDEC_ID[7:0];
    assign byte_v  = (src_q == SRC_MEM) ? pf_q : (src_q == SRC_ID) ? id_byte : 8'h00;

    // A CS fall is only honoured once CS has been seen high after reset, so a reset
    // in mid-transaction drops the remainder of that transaction.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        pf_d    = cap_q ? MEM_RDATA : pf_q;
        miso_d  = miso_q;
        oe_d    = oe_q;
        rd_d    = req_q;
        addr_d  = req_q ? addr_q + MEM_AW'(1) : addr_q;
        req_d   = 1'b0;
        cap_d   = rd_q;
        src_d   = src_q;
        idx_d   = idx_q;
        load_d  = load_q;
        warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        armed_d = armed_q | ((warm_q == 2'd3) & cs_s);
        if (cs_rise) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sh_d    = '0;
            tx_d    = '0;
            miso_d  = 1'b0;
            oe_d    = 1'b0;
            rd_d    = 1'b0;
            load_d  = 1'b0;
            idx_d   = '0;
        end else if (cs_fall && armed_q) begin
            state_d = ST_CMD;
            cnt_d   = '0;
            oe_d    = 1'b1;
            miso_d  = 1'b0;
            load_d  = 1'b0;
            idx_d   = '0;
        end else if (sclk_rise && state_q inside {ST_CMD, ST_ADDR, ST_DATA}) begin
            sh_d  = {sh_q[MEM_AW-3:0], mosi};
            cnt_d = cnt_q + 5'd1;
            if (state_q == ST_CMD && cnt_q == 5'd7) begin
                cnt_d   = '0;
                src_d   = (cmd == CMD_RDID) ? SRC_ID : (cmd == CMD_RDSR) ? SRC_SR : SRC_MEM;
                state_d = (cmd == CMD_READ) ? ST_ADDR :
                          (cmd == CMD_RDID || cmd == CMD_RDSR) ? ST_DATA : ST_IGNORE;
                load_d  = (cmd == CMD_RDID || cmd == CMD_RDSR);
            end
            if (state_q == ST_ADDR && cnt_q == 5'd23) begin
                cnt_d   = '0;
                state_d = ST_DATA;
                rd_d    = 1'b1;
                addr_d  = {sh_q, mosi};
                load_d  = 1'b1;
            end
            if (state_q == ST_DATA && cnt_q == 5'd7) begin
                cnt_d  = '0;
                load_d = 1'b1;
            end
        end else if (sclk_fall && state_q == ST_DATA) begin
            if (load_q) begin
                miso_d = byte_v[7];
                tx_d   = {byte_v[6:0], 1'b0};
                load_d = 1'b0;
                idx_d  = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
                req_d  = (src_q == SRC_MEM);
            end else begin
                miso_d = tx_q[7];
                tx_d   = {tx_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            addr_q  <= '0;
            tx_q    <= '0;
            pf_q    <= '0;
            miso_q  <= 1'b0;
            oe_q    <= 1'b0;
            rd_q    <= 1'b0;
            req_q   <= 1'b0;
            cap_q   <= 1'b0;
            src_q   <= '0;
            idx_q   <= '0;
            load_q  <= 1'b0;
            warm_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            tx_q    <= tx_d;
            pf_q    <= pf_d;
            miso_q  <= miso_d;
            oe_q    <= oe_d;
            rd_q    <= rd_d;
            req_q   <= req_d;
            cap_q   <= cap_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
            load_q  <= load_d;
            warm_q  <= warm_d;
            armed_q <= armed_d;
        end
    end

    assign SPI_MISO = miso_q;
    assign MISO_OE  = oe_q;
    assign MEM_RD   = rd_q;
    assign MEM_ADDR = addr_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: directed SPI transactions against a synchronous byte-memory model.
module tb_spi_flash_responder;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SPI_CS = 1'b1;
    logic        SPI_SCLK = 1'b0;
    logic        SPI_MOSI = 1'b0;
    logic        SPI_MISO, MISO_OE, MEM_RD;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_RDATA = 8'h00;
    logic [7:0]  mem [0:65535];
    logic [15:0] rd_log [$];
    logic [7:0]  rbuf [0:7];
    int          miso_hi = 0;
    int          checks = 0;
    int          passed = 0;

    spi_flash_responder #(.MEM_AW(16), .JEDEC_ID(24'hEF4016)) dut (
        .CLK(CLK), .RST(RST), .SPI_CS(SPI_CS), .SPI_SCLK(SPI_SCLK), .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO), .MISO_OE(MISO_OE), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
        .MEM_RDATA(MEM_RDATA)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (MEM_RD) MEM_RDATA <= mem[MEM_ADDR];

    always @(negedge CLK) begin
        if (MEM_RD) rd_log.push_back(MEM_ADDR);
        if (SPI_MISO) miso_hi <= miso_hi + 1;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", passed, checks);
        $fatal(1);
    end

    // SCLK half period 50 ns = 5 CLK periods; MISO sampled just before each rising SCLK.
    task automatic xfer(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            SPI_MOSI = tx[i];
            #50;
            rx = {rx[6:0], SPI_MISO};
            SPI_SCLK = 1'b1;
            #50;
            SPI_SCLK = 1'b0;
        end
    endtask

    task automatic cs_begin;
        SPI_CS = 1'b0;
        #100;
    endtask

    task automatic cs_end;
        #100;
        SPI_CS = 1'b1;
        #300;
    endtask

    task automatic spi_read(input logic [23:0] a, input int n);
        logic [7:0] rx;
        cs_begin;
        xfer(8'h03, 8, rx);
        xfer(a[23:16], 8, rx);
        xfer(a[15:8], 8, rx);
        xfer(a[7:0], 8, rx);
        for (int i = 0; i < n; i++) begin
            xfer(8'h00, 8, rx);
            rbuf[i] = rx;
        end
        cs_end;
    endtask

    task automatic test_reset;
        repeat (4) @(negedge CLK);
        checks++; if (SPI_MISO !== 1'b0) $display("FAIL reset_miso got %b want 0", SPI_MISO); else passed++;
        checks++; if (MISO_OE !== 1'b0) $display("FAIL reset_oe got %b want 0", MISO_OE); else passed++;
        checks++; if (MEM_RD !== 1'b0) $display("FAIL reset_rd got %b want 0", MEM_RD); else passed++;
        checks++; if (MEM_ADDR !== 16'h0) $display("FAIL reset_addr got %h want 0000", MEM_ADDR); else passed++;
        RST = 1'b0;
        repeat (10) @(negedge CLK);
    endtask

    task automatic test_read;
        logic [7:0] exp [0:3];
        int base;
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        base = rd_log.size();
        spi_read(24'h000010, 4);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rbuf[b] !== exp[b]) $display("FAIL read_byte%0d got %h want %h", b, rbuf[b], exp[b]); else passed++;
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (rd_log.size() <= base + b || rd_log[base + b] !== 16'h0010 + 16'(b))
                $display("FAIL read_memrd%0d got %h want %h", b, (rd_log.size() > base + b) ? rd_log[base + b] : 16'hxxxx, 16'h0010 + 16'(b));
            else passed++;
        end
        checks++; if (MISO_OE !== 1'b0) $display("FAIL read_oe_after got %b want 0", MISO_OE); else passed++;
    endtask

    task automatic test_rdid;
        logic [7:0] rx;
        logic [7:0] exp [0:5];
        int base;
        exp = '{8'hEF, 8'h40, 8'h16, 8'hEF, 8'h40, 8'h16};
        base = rd_log.size();
        cs_begin;
        xfer(8'h9F, 8, rx);
        checks++; if (MISO_OE !== 1'b1) $display("FAIL rdid_oe got %b want 1", MISO_OE); else passed++;
        for (int b = 0; b < 6; b++) begin
            xfer(8'h00, 8, rx);
            checks++;
            if (rx !== exp[b]) $display("FAIL rdid_byte%0d got %h want %h", b, rx, exp[b]); else passed++;
        end
        cs_end;
        checks++; if (rd_log.size() != base) $display("FAIL rdid_no_memrd got %0d want 0", rd_log.size() - base); else passed++;
    endtask

    task automatic test_wrap;
        int base;
        base = rd_log.size();
        spi_read(24'h00FFFF, 2);
        checks++; if (rbuf[0] !== 8'hA5) $display("FAIL wrap_byte0 got %h want a5", rbuf[0]); else passed++;
        checks++; if (rbuf[1] !== 8'h5A) $display("FAIL wrap_byte1 got %h want 5a", rbuf[1]); else passed++;
        checks++;
        if (rd_log.size() < base + 2 || rd_log[base] !== 16'hFFFF || rd_log[base + 1] !== 16'h0000)
            $display("FAIL wrap_memrd got %0d pulses want ffff then 0000", rd_log.size() - base);
        else passed++;
    endtask

    task automatic test_unknown;
        logic [7:0] rx;
        int base, hi0;
        base = rd_log.size();
        hi0 = miso_hi;
        cs_begin;
        xfer(8'hAB, 8, rx);
        xfer(8'h00, 8, rx);
        checks++; if (rx !== 8'h00) $display("FAIL unk_byte0 got %h want 00", rx); else passed++;
        xfer(8'h00, 8, rx);
        checks++; if (rx !== 8'h00) $display("FAIL unk_byte1 got %h want 00", rx); else passed++;
        cs_end;
        checks++; if (miso_hi != hi0) $display("FAIL unk_miso_high got %0d cycles want 0", miso_hi - hi0); else passed++;
        checks++; if (rd_log.size() != base) $display("FAIL unk_no_memrd got %0d want 0", rd_log.size() - base); else passed++;
        spi_read(24'h000010, 1);
        checks++; if (rbuf[0] !== 8'h11) $display("FAIL unk_then_read got %h want 11", rbuf[0]); else passed++;
    endtask

    task automatic test_abort;
        logic [7:0] rx;
        int hi0;
        cs_begin;
        xfer(8'h03, 8, rx);
        xfer(8'h00, 8, rx);
        xfer(8'h00, 8, rx);
        xfer(8'h10, 8, rx);
        xfer(8'h00, 8, rx);
        checks++; if (rx !== 8'h11) $display("FAIL abort_first got %h want 11", rx); else passed++;
        xfer(8'h00, 3, rx);
        cs_end;
        hi0 = miso_hi;
        cs_begin;
        xfer(8'h05, 8, rx);
        xfer(8'h00, 8, rx);
        checks++; if (rx !== 8'h00) $display("FAIL abort_rdsr0 got %h want 00", rx); else passed++;
        xfer(8'h00, 8, rx);
        checks++; if (rx !== 8'h00) $display("FAIL abort_rdsr1 got %h want 00", rx); else passed++;
        cs_end;
        checks++; if (miso_hi != hi0) $display("FAIL abort_residual got %0d high cycles want 0", miso_hi - hi0); else passed++;
    endtask

    task automatic test_rst_mid;
        logic [7:0] rx;
        int base;
        cs_begin;
        xfer(8'h03, 8, rx);
        xfer(8'h00, 8, rx);
        xfer(8'h00, 4, rx);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++; if (SPI_MISO !== 1'b0) $display("FAIL rst_miso got %b want 0", SPI_MISO); else passed++;
        checks++; if (MISO_OE !== 1'b0) $display("FAIL rst_oe got %b want 0", MISO_OE); else passed++;
        checks++; if (MEM_RD !== 1'b0) $display("FAIL rst_rd got %b want 0", MEM_RD); else passed++;
        checks++; if (MEM_ADDR !== 16'h0) $display("FAIL rst_addr got %h want 0000", MEM_ADDR); else passed++;
        base = rd_log.size();
        xfer(8'h00, 4, rx);
        xfer(8'h12, 8, rx);
        xfer(8'h00, 8, rx);
        checks++; if (MISO_OE !== 1'b0) $display("FAIL rst_ignore_oe got %b want 0", MISO_OE); else passed++;
        checks++; if (rx !== 8'h00) $display("FAIL rst_ignore_data got %h want 00", rx); else passed++;
        cs_end;
        checks++; if (rd_log.size() != base) $display("FAIL rst_ignore_memrd got %0d want 0", rd_log.size() - base); else passed++;
        spi_read(24'h000012, 1);
        checks++; if (rbuf[0] !== 8'h33) $display("FAIL rst_then_read got %h want 33", rbuf[0]); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'h11;
        mem[16'h0011] = 8'h22;
        mem[16'h0012] = 8'h33;
        mem[16'h0013] = 8'h44;
        mem[16'hFFFF] = 8'hA5;
        mem[16'h0000] = 8'h5A;
        test_reset;
        test_read;
        test_rdid;
        test_wrap;
        test_unknown;
        test_abort;
        test_rst_mid;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
